// File: rtl/pc_sequencer_if.sv
// Fetch-side and issue-side handshake bundle between the PC sequencer,
// the instruction memory and the datapath.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction at a time, hands it to the
// datapath, follows redirects and halts on misalignment, bus timeout or request.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          ACK_TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               reset,
  pc_sequencer_if.master     bus,
  output logic [31:0]        pc_out,
  input  logic               redirect,
  input  logic [31:0]        redirect_target,
  input  logic               halt_req,
  output logic               halted,
  output logic               err_misalign,
  output logic               err_bus
);

  typedef enum logic [1:0] {RST_WAIT, FETCH, ISSUE, HALTED} state_t;

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] target_q, target_d;
  logic        flush_q, flush_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        em_q, em_d;
  logic        eb_q, eb_d;

  logic        misaligned;
  logic        flush_now;
  logic [31:0] target_now;

  assign misaligned = redirect && (redirect_target[1:0] != 2'b00);
  // A redirect arriving in the same cycle as the ack still kills the word.
  assign flush_now  = flush_q || redirect;
  assign target_now = redirect ? redirect_target : target_q;

  // NOTE: reset is synchronous here, so it lives inside the clocked branch and
  // every register, including the instruction word, is given a defined value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= RST_WAIT;
      pc_q     <= RESET_VECTOR;
      instr_q  <= 32'h0;
      target_q <= 32'h0;
      flush_q  <= 1'b0;
      cnt_q    <= 8'h0;
      em_q     <= 1'b0;
      eb_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      target_q <= target_d;
      flush_q  <= flush_d;
      cnt_q    <= cnt_d;
      em_q     <= em_d;
      eb_q     <= eb_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default on every variable keeps this block free of latches.
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    target_d = target_q;
    flush_d  = flush_q;
    cnt_d    = cnt_q;
    em_d     = em_q;
    eb_d     = eb_q;
    unique case (state_q)
      RST_WAIT: begin
        state_d = FETCH;
        cnt_d   = 8'h0;
        flush_d = 1'b0;
      end
      FETCH: begin
        if (misaligned) begin
          em_d    = 1'b1;
          state_d = HALTED;
        end else if (bus.imem_ack) begin
          cnt_d = 8'h0;
          if (flush_now) begin
            pc_d    = target_now;
            flush_d = 1'b0;
          end else begin
            instr_d = bus.imem_rdata;
            state_d = ISSUE;
          end
        end else if (cnt_q == CNT_LAST) begin
          eb_d    = 1'b1;
          state_d = HALTED;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (redirect) begin
            flush_d  = 1'b1;
            target_d = redirect_target;
          end
        end
      end
      ISSUE: begin
        if (bus.instr_ready) begin
          if (misaligned) begin
            em_d    = 1'b1;
            state_d = HALTED;
          end else begin
            pc_d    = redirect ? redirect_target : pc_q + 32'd4;
            state_d = halt_req ? HALTED : FETCH;
            cnt_d   = 8'h0;
            flush_d = 1'b0;
          end
        end
      end
      HALTED: ;
      default: state_d = RST_WAIT;
    endcase
  end

  always_comb begin
    bus.imem_req    = (state_q == FETCH);
    bus.instr_valid = (state_q == ISSUE);
    halted          = (state_q == HALTED);
    bus.imem_addr   = pc_q;
    bus.instr_out   = instr_q;
    pc_out          = pc_q;
    err_misalign    = em_q;
    err_bus         = eb_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (ACK_TIMEOUT=4) plus hand-written
// sequences for reset during a fetch and a misaligned redirect while fetching.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_out;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        halted;
  logic        err_misalign;
  logic        err_bus;

  int checks   = 0;
  int failures = 0;
  bit running  = 1'b0;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_VECTOR(32'h0), .ACK_TIMEOUT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .pc_out          (pc_out),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .halted          (halted),
    .err_misalign    (err_misalign),
    .err_bus         (err_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        rdr;
    logic [31:0] tgt;
    logic        hlt;
    logic        e_req;
    logic        e_vld;
    logic [31:0] e_io;
    logic [31:0] e_pc;
    logic [2:0]  e_flags;   // {halted, err_misalign, err_bus}
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, ack, input logic [31:0] rdata,
                              input logic rdy, rdr, input logic [31:0] tgt, input logic hlt,
                              input logic e_req, e_vld, input logic [31:0] e_io, e_pc,
                              input logic [2:0] e_flags);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.rdr = rdr;
    v.tgt = tgt; v.hlt = hlt; v.e_req = e_req; v.e_vld = e_vld;
    v.e_io = e_io; v.e_pc = e_pc; v.e_flags = e_flags;
    return v;
  endfunction

  // Fetch and issue must never overlap, checked every cycle once out of reset.
  always @(negedge clk) begin
    if (running) check("vld_req_exclusive", 128'(bus.instr_valid & bus.imem_req), 128'h0);
  end

  localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA000_0001, A2 = 32'hA000_0002,
                          A3 = 32'hA000_0003, A4 = 32'hA000_0004, A5 = 32'hA000_0005,
                          A6 = 32'hA000_0006, DEAD = 32'hDEAD_BEEF, TOP = 32'hFFFF_FFFC;

  initial begin
    // rst ack rdata rdy rdr tgt hlt | req vld instr_out pc flags
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 0,0,0, 0,    3'b000)); // 0 RST_WAIT
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 1,0,0, 0,    3'b000)); // 1 fetch 0x0
    vecs.push_back(mk(1,1,A0,  0,0,0,     0, 1,0,0, 0,    3'b000)); // 2 ack
    vecs.push_back(mk(1,0,0,   1,0,0,     0, 0,1,A0,0,    3'b000)); // 3 issue
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 1,0,A0,4,    3'b000)); // 4 fetch 0x4
    vecs.push_back(mk(1,1,A1,  0,0,0,     0, 1,0,A0,4,    3'b000)); // 5
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 0,1,A1,4,    3'b000)); // 6 stall
    vecs.push_back(mk(1,0,0,   1,0,0,     0, 0,1,A1,4,    3'b000)); // 7
    vecs.push_back(mk(1,0,0,   0,1,32'h200,0,1,0,A1,8,    3'b000)); // 8 redirect in fetch
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 1,0,A1,8,    3'b000)); // 9
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 1,0,A1,8,    3'b000)); // 10
    vecs.push_back(mk(1,1,DEAD,0,0,0,     0, 1,0,A1,8,    3'b000)); // 11 ack discarded
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 1,0,A1,32'h200,3'b000)); // 12
    vecs.push_back(mk(1,1,A2,  0,0,0,     0, 1,0,A1,32'h200,3'b000)); // 13
    vecs.push_back(mk(1,0,0,   1,1,32'h100,0,0,1,A2,32'h200,3'b000)); // 14 redirect in issue
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 1,0,A2,32'h100,3'b000)); // 15
    vecs.push_back(mk(1,1,A3,  0,0,0,     0, 1,0,A2,32'h100,3'b000)); // 16
    vecs.push_back(mk(1,0,0,   1,1,TOP,   0, 0,1,A3,32'h100,3'b000)); // 17
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 1,0,A3,TOP,  3'b000)); // 18
    vecs.push_back(mk(1,1,A4,  0,0,0,     0, 1,0,A3,TOP,  3'b000)); // 19
    vecs.push_back(mk(1,0,0,   1,0,0,     0, 0,1,A4,TOP,  3'b000)); // 20 wrap
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 1,0,A4,0,    3'b000)); // 21
    vecs.push_back(mk(1,1,A5,  0,0,0,     0, 1,0,A4,0,    3'b000)); // 22
    vecs.push_back(mk(1,0,0,   1,0,0,     1, 0,1,A5,0,    3'b000)); // 23 halt_req
    vecs.push_back(mk(1,1,0,   1,1,32'h300,1,0,0,A5,4,    3'b100)); // 24 halted ignores all
    vecs.push_back(mk(0,0,0,   0,0,0,     0, 0,0,A5,4,    3'b100)); // 25 reset
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 0,0,0, 0,    3'b000)); // 26 RST_WAIT
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 1,0,0, 0,    3'b000)); // 27 no ack x4
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 1,0,0, 0,    3'b000)); // 28
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 1,0,0, 0,    3'b000)); // 29
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 1,0,0, 0,    3'b000)); // 30
    vecs.push_back(mk(0,0,0,   0,0,0,     0, 0,0,0, 0,    3'b101)); // 31 bus error
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 0,0,0, 0,    3'b000)); // 32
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 1,0,0, 0,    3'b000)); // 33
    vecs.push_back(mk(1,1,A6,  0,0,0,     0, 1,0,0, 0,    3'b000)); // 34
    vecs.push_back(mk(1,0,0,   1,1,32'h102,0,0,1,A6,0,    3'b000)); // 35 misaligned
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 0,0,A6,0,    3'b110)); // 36
    vecs.push_back(mk(0,0,0,   0,0,0,     0, 0,0,A6,0,    3'b110)); // 37 reset
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 0,0,0, 0,    3'b000)); // 38
    vecs.push_back(mk(1,0,0,   0,0,0,     0, 1,0,0, 0,    3'b000)); // 39 fetch at vector

    reset = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b0;
    redirect = 1'b0; redirect_target = 32'h0; halt_req = 1'b0;
    repeat (2) @(posedge clk);
    running = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      reset = v.rst; bus.imem_ack = v.ack; bus.imem_rdata = v.rdata;
      bus.instr_ready = v.rdy; redirect = v.rdr; redirect_target = v.tgt; halt_req = v.hlt;
      check($sformatf("row%0d", i),
            {bus.imem_req, bus.instr_valid, bus.instr_out, pc_out, halted, err_misalign, err_bus},
            {v.e_req, v.e_vld, v.e_io, v.e_pc, v.e_flags});
      if (v.e_req) check($sformatf("row%0d_addr", i), 128'(bus.imem_addr), 128'(v.e_pc));
    end

    // Reset while fetching, then a late ack during RST_WAIT must be ignored.
    @(negedge clk);
    reset = 1'b0; bus.imem_ack = 1'b0; bus.instr_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_fetch_req", 128'(bus.imem_req), 128'h0);
    reset = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = DEAD;
    @(negedge clk);
    check("late_ack_ignored", {bus.imem_req, bus.instr_valid, bus.instr_out, pc_out},
          {1'b1, 1'b0, 32'h0, 32'h0});

    // Misaligned redirect captured during FETCH halts without fetching it.
    bus.imem_ack = 1'b0; redirect = 1'b1; redirect_target = 32'h41;
    @(negedge clk);
    redirect = 1'b0;
    check("fetch_misalign", {bus.imem_req, halted, err_misalign, err_bus, pc_out},
          {1'b0, 1'b1, 1'b1, 1'b0, 32'h0});

    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter ACK_TIMEOUT, default 16, max cycles waiting for imem_ack before bus error (range 2..255).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 imem_req  output  1  instruction fetch request, held until ack.
REQ-006 imem_addr  output  32  fetch address; equals pc_out whenever imem_req=1.
REQ-007 imem_ack  input  1  memory accepted request; imem_rdata valid same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr_valid  output  1  instr_out holds an instruction for the datapath.
REQ-010 instr_ready  input  1  datapath consumes instr_out this cycle.
REQ-011 instr_out  output  32  registered instruction word.
REQ-012 pc_out  output  32  address of current/in-flight instruction.
REQ-013 redirect  input  1  branch taken or jump; valid only with redirect_target.
REQ-014 redirect_target  input  32  next PC on redirect.
REQ-015 halt_req  input  1  stop fetching after current instruction retires.
REQ-016 halted  output  1  sequencer in HALTED state.
REQ-017 err_misalign  output  1  sticky: redirect_target[1:0] != 0 seen.
REQ-018 err_bus  output  1  sticky: ack timeout occurred.

Function
REQ-019 FSM states SHALL be RST_WAIT, FETCH, ISSUE, HALTED; all registers update on rising clk only.
REQ-020 RST_WAIT: one cycle, no request; next state FETCH, pc_out=RESET_VECTOR.
REQ-021 FETCH: imem_req=1, imem_addr=pc_out; wait counter increments each cycle without ack, cleared on entry.
REQ-022 FETCH with imem_ack=1 and no pending flush: instr_out<=imem_rdata, next state ISSUE (instr_valid=1 next cycle); minimum fetch latency 1 cycle after req.
REQ-023 FETCH with wait counter reaching ACK_TIMEOUT and no ack: err_bus<=1, next state HALTED, imem_req deasserted.
REQ-024 ISSUE: instr_valid=1, instr_out and pc_out stable until instr_ready=1.
REQ-025 ISSUE with instr_ready=1: pc_out<=redirect ? redirect_target : pc_out+32'd4 (modulo 2^32, wrap 32'hFFFF_FFFC -> 32'h0); next state FETCH, or HALTED if halt_req=1 same cycle (PC still updated).
REQ-026 redirect/halt_req SHALL be ignored when not in ISSUE with instr_ready=1, except REQ-027.
REQ-027 redirect=1 during FETCH: capture redirect_target, set flush flag; on ack the fetched word SHALL be discarded, pc_out<=captured target, stay FETCH with counter cleared; a second redirect before ack overwrites the target.
REQ-028 Any accepted redirect with redirect_target[1:0]!=0: err_misalign<=1, next state HALTED, no fetch issued to misaligned address.
REQ-029 HALTED: imem_req=0, instr_valid=0, halted=1, pc_out frozen; exit only by reset.
REQ-030 instr_valid SHALL never be 1 in same cycle as imem_req.

Reset
REQ-031 reset=0 at a clk edge SHALL force state RST_WAIT, pc_out=RESET_VECTOR, instr_out=0, imem_req=0, instr_valid=0, halted=0, err_misalign=0, err_bus=0, flush flag and counter cleared.
REQ-032 Reset mid-FETCH SHALL drop imem_req next cycle; a late imem_ack arriving in RST_WAIT SHALL be ignored.
REQ-033 Outputs SHALL be defined (no X) from the first edge with reset=0.

Verification
REQ-034 Reset release, ack 1 cycle after each req, instr_ready=1 always -> imem_addr sequence 0x0,0x4,0x8; instr_out matches rdata; one instruction per 3 cycles.
REQ-035 ISSUE at pc=0x10, redirect=1 target=0x100, instr_ready=1 -> next imem_addr=0x100.
REQ-036 redirect target=0x200 during FETCH of 0x8, ack 3 cycles later -> word discarded, instr_valid stays 0, next imem_addr=0x200.
REQ-037 ACK_TIMEOUT=4, ack never asserted -> err_bus=1 and halted=1 after 4 FETCH cycles, imem_req=0.
REQ-038 redirect target=0x102 -> err_misalign=1, halted=1, no req to 0x102; then reset=0 one cycle -> flags clear, fetch at RESET_VECTOR.
REQ-039 pc=0xFFFF_FFFC, instr_ready=1, no redirect -> next imem_addr=0x0000_0000.
